score_board: RTL and testbench
==============================

Name: score_board

Overview:
- Pong scoring stage that sits beside the ball, paddle and hit-detector stages.
- Consumes the ball video bit, the ball X direction and the VGA timing strobes.
- Counts paddle returns as a two-digit BCD score and detects misses at the left screen edge.
- Produces a 1-bit on-screen score overlay, which the top level ORs into the VGA video input with the ball and paddle bits.

Parameters:
- DIGIT_X, 16, left pixel column of the tens digit.
- DIGIT_Y, 8, top pixel row of both digits.
- SCALE_LOG2, 2, each font pixel is drawn as a 2^SCALE_LOG2 square.
- MISS_COLS, 4, width in columns of the left-edge miss zone (columns 0..MISS_COLS-1).
- COL_W, 10, width of the internal column and row counters.

Ports:
- i_Clk  in  1  pixel clock.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_HBlank  in  1  high outside the active horizontal region.
- i_VBlank  in  1  high outside the active vertical region.
- i_HReset  in  1  one-cycle pulse at the start of each line.
- i_VReset  in  1  one-cycle pulse at the start of each frame.
- i_Ball  in  1  ball video bit for the current pixel.
- i_XDir  in  1  ball X direction; 1 = moving right.
- o_Video  out  1  score overlay pixel, registered.
- o_Score  out  8  committed BCD score, {tens, ones}.
- o_Miss  out  1  one-cycle pulse when a miss is committed.

Behaviour:
- Reset: i_Rst_n low asynchronously clears all registers. Counters = 0, o_Score = 8'h00, o_Video = 0, o_Miss = 0, FSM = IDLE.
- Column counter: cleared by i_HReset. Increments on every cycle with i_HBlank low. Holds while i_HBlank is high.
- Row counter: cleared by i_VReset. Increments on i_HReset only while i_VBlank is low.
- If i_HReset and i_VReset coincide, both counters clear.
- Counters saturate at 2^COL_W-1; they never wrap.
- Hit event: a registered 0->1 edge of i_XDir (bounce off the paddle) sets pending_hit.
- Miss zone: i_Ball high with column < MISS_COLS during active video sets pending_miss.
- Miss FSM states:
  - IDLE: pending_miss at i_VReset -> MISS.
  - MISS: one cycle. Pulse o_Miss, clear the score to 00, then -> COOLDOWN.
  - COOLDOWN: at each i_VReset, if no ball pixel hit the miss zone in the previous frame -> IDLE; otherwise stay.
  - Purpose: one miss counts once, even though the ball spans many frames at the edge.
- Score commit happens only on the i_VReset cycle, so there is no tearing. Order on that cycle:
  - miss has priority over hit (score -> 00);
  - otherwise a hit increments the BCD score: ones 9 -> 0 with a carry into tens;
  - 99 saturates at 99;
  - pending_hit and pending_miss are cleared on the same edge.
- Hits arriving during COOLDOWN are still counted.
- Rendering:
  - Digit cell = 4 font columns (3 lit + 1 gap) by 5 font rows, each scaled by 2^SCALE_LOG2.
  - Tens digit starts at DIGIT_X; ones digit starts at DIGIT_X + 4*2^SCALE_LOG2.
  - Font column and row = pixel offset >> SCALE_LOG2.
  - Font is a 3x5 ROM lookup of 10 glyphs x 15 bits. The gap column is always 0.
  - A leading tens 0 is blanked (score 07 shows only "7").
  - o_Video = 0 whenever i_HBlank or i_VBlank is high.
- Latency: o_Video is registered, one cycle behind the counter position. The ball and paddle stages register their video identically, so the overlay aligns with them.
- Reset mid-frame: counters restart from 0, and the overlay is garbled until the next i_VReset. This is acceptable.

Test Plan:
- Reset low mid-line -> all outputs immediately 0. After release with no events, o_Score stays 8'h00 across 3 frames.
- 12 i_XDir 0->1 edges, one per frame -> o_Score = 8'h12. Digit pixels match the ROM at DIGIT_X=16, DIGIT_Y=8 with SCALE_LOG2=2.
- Score 8'h99 plus one further hit -> o_Score stays 8'h99. Score 8'h09 plus one hit -> 8'h10.
- Ball pixel in column 2 for 5 consecutive frames -> exactly one o_Miss pulse, on the first i_VReset. o_Score = 00. FSM stays in COOLDOWN until the first ball-free frame.
- Hit edge and miss zone hit in the same frame -> at i_VReset o_Score = 00, o_Miss pulses, and no increment.
- Score 8'h07 -> no overlay pixels in the tens cell. Pixels present in the ones cell. Overlay is 0 during blanking.

Source files
------------

// File: rtl/score_board.sv
// Pong scoring stage: counts paddle returns as a two-digit BCD score, detects
// left-edge misses and draws the score as a 1-bit scaled 3x5 font overlay.
module score_board #(
  parameter int DIGIT_X    = 16,
  parameter int DIGIT_Y    = 8,
  parameter int SCALE_LOG2 = 2,
  parameter int MISS_COLS  = 4,
  parameter int COL_W      = 10
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_Ball,
  input  logic       i_XDir,
  output logic       o_Video,
  output logic [7:0] o_Score,
  output logic       o_Miss
);

  localparam logic [COL_W-1:0] MISS_LIM = COL_W'(MISS_COLS);
  localparam logic [COL_W-1:0] CELL_W   = COL_W'(4 << SCALE_LOG2);
  localparam logic [COL_W-1:0] X_START  = COL_W'(DIGIT_X);
  localparam logic [COL_W-1:0] X_END    = COL_W'(DIGIT_X + (8 << SCALE_LOG2));
  localparam logic [COL_W-1:0] Y_START  = COL_W'(DIGIT_Y);
  localparam logic [COL_W-1:0] Y_END    = COL_W'(DIGIT_Y + (5 << SCALE_LOG2));

  typedef enum logic [1:0] {IDLE, MISS, COOLDOWN} state_t;

  state_t           state, state_next;
  logic [COL_W-1:0] col, row;
  logic             xdir_q;
  logic             pending_hit, pending_miss;
  logic             hit_edge, miss_px, miss_commit;
  logic [7:0]       score;
  logic             video;

  logic [COL_W-1:0] dx, dy;
  logic             in_x, in_y, ones_sel, tens_blank, pix;
  logic [1:0]       fcol;
  logic [2:0]       frow;
  logic [3:0]       digit, bit_idx;
  logic [14:0]      glyph_bits;

  // Glyph rows top to bottom, 3 bits each, MSB is the leftmost font column.
  function automatic logic [14:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 15'b111_101_101_101_111;
      4'd1:    return 15'b010_110_010_010_111;
      4'd2:    return 15'b111_001_111_100_111;
      4'd3:    return 15'b111_001_111_001_111;
      4'd4:    return 15'b101_101_111_001_001;
      4'd5:    return 15'b111_100_111_001_111;
      4'd6:    return 15'b111_100_111_101_111;
      4'd7:    return 15'b111_001_001_001_001;
      4'd8:    return 15'b111_101_111_101_111;
      4'd9:    return 15'b111_101_111_001_111;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      if (i_HReset)
        col <= '0;
      else if (!i_HBlank && col != '1)
        col <= col + 1'b1;
      if (i_VReset)
        row <= '0;
      else if (i_HReset && !i_VBlank && row != '1)
        row <= row + 1'b1;
    end
  end

  always_comb begin
    hit_edge    = i_XDir & ~xdir_q;
    miss_px     = i_Ball && !i_HBlank && !i_VBlank && (col < MISS_LIM);
    miss_commit = i_VReset && pending_miss && (state == IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      xdir_q       <= 1'b0;
      pending_hit  <= 1'b0;
      pending_miss <= 1'b0;
    end else begin
      xdir_q <= i_XDir;
      if (i_VReset) begin
        pending_hit  <= 1'b0;
        pending_miss <= 1'b0;
      end else begin
        if (hit_edge) pending_hit  <= 1'b1;
        if (miss_px)  pending_miss <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // While in COOLDOWN, pending_miss doubles as "ball touched the zone last frame".
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (i_VReset && pending_miss) state_next = MISS;
      MISS:     state_next = COOLDOWN;
      COOLDOWN: if (i_VReset && !pending_miss) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    o_Miss = (state == MISS);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      score <= '0;
    end else if (miss_commit || state == MISS) begin
      score <= '0;
    end else if (i_VReset && pending_hit && score != 8'h99) begin
      if (score[3:0] == 4'd9)
        score <= {score[7:4] + 4'd1, 4'd0};
      else
        score <= {score[7:4], score[3:0] + 4'd1};
    end
  end

  // Font column wraps modulo 4 so the same shift serves both digit cells.
  always_comb begin
    dx         = col - X_START;
    dy         = row - Y_START;
    in_x       = (col >= X_START) && (col < X_END);
    in_y       = (row >= Y_START) && (row < Y_END);
    ones_sel   = (dx >= CELL_W);
    fcol       = 2'(dx >> SCALE_LOG2);
    frow       = 3'(dy >> SCALE_LOG2);
    digit      = ones_sel ? score[3:0] : score[7:4];
    tens_blank = !ones_sel && (score[7:4] == 4'd0);
    glyph_bits = glyph(digit);
    bit_idx    = 4'd14 - (4'(frow) * 4'd3 + 4'(fcol));
    pix        = !i_HBlank && !i_VBlank && in_x && in_y && (fcol != 2'd3)
                 && !tens_blank && glyph_bits[bit_idx];
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      video <= 1'b0;
    else
      video <= pix;
  end

  assign o_Video = video;
  assign o_Score = score;

endmodule

// File: tb/tb_score_board.sv
// Self-checking bench for score_board: drives synthetic video timing with random
// ball noise and compares against a frame-level scoring and font model.
module tb_score_board;

  localparam int DX = 16;
  localparam int DY = 8;
  localparam int SL = 2;
  localparam int MC = 4;
  localparam int HB = 4;
  localparam int VB = 2;
  localparam int R_HACT = 52;
  localparam int R_VACT = 30;
  localparam int F_HACT = 8;
  localparam int F_VACT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hblank = 1'b1, vblank = 1'b1, hreset = 1'b0, vreset = 1'b0;
  logic       ball = 1'b0, xdir = 1'b0;
  logic       video;
  logic [7:0] score;
  logic       miss;

  int total = 0;
  int bad = 0;

  int m_score = 0;
  bit m_ph = 0, m_pm = 0, m_cool = 0, m_prev = 0;

  int st_tens, st_ones, st_blank, st_miss;

  int font [10][5] = '{
    '{7,5,5,5,7}, '{2,6,2,2,7}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
    '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,7}};

  score_board #(
    .DIGIT_X(DX), .DIGIT_Y(DY), .SCALE_LOG2(SL), .MISS_COLS(MC), .COL_W(10)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_HBlank(hblank), .i_VBlank(vblank),
    .i_HReset(hreset), .i_VReset(vreset), .i_Ball(ball), .i_XDir(xdir),
    .o_Video(video), .o_Score(score), .o_Miss(miss)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int s);
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  function automatic bit exp_pix(input int col, input int row, input int s);
    int d, fc, fr, dig;
    int unit = 1 << SL;
    if (col < DX || col >= DX + 8 * unit || row < DY || row >= DY + 5 * unit) return 0;
    d  = (col - DX) / (4 * unit);
    fc = ((col - DX) % (4 * unit)) / unit;
    fr = (row - DY) / unit;
    if (fc == 3) return 0;
    if (d == 0 && s / 10 == 0) return 0;
    dig = (d == 0) ? s / 10 : s % 10;
    return 1'((font[dig][fr] >> (2 - fc)) & 1);
  endfunction

  task automatic set_idle();
    hblank = 1'b1; vblank = 1'b1; hreset = 1'b0; vreset = 1'b0;
    ball = 1'b0; xdir = 1'b0;
  endtask

  task automatic model_reset();
    m_score = 0; m_ph = 0; m_pm = 0; m_cool = 0; m_prev = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic do_reset();
    set_idle();
    #2 rst_n = 1'b0;
    release_reset();
  endtask

  // One frame starting at its VReset cycle; stop_at < 0 runs the whole frame.
  task automatic run_frame(input int hact, input int vact, input bit do_hit,
                           input bit do_miss, input int stop_at);
    int lw = HB + hact;
    int nl = VB + vact;
    int n  = lw * nl;
    int hit_idx = do_hit ? int'($urandom_range(n - 1, 1)) : -1;
    int vid_err = 0, miss_err = 0, first_l = -1, first_c = -1;
    st_tens = 0; st_ones = 0; st_blank = 0; st_miss = 0;
    for (int idx = 0; idx < n; idx++) begin
      int l = idx / lw;
      int c = idx % lw;
      int col = c - HB;
      int row = l - VB + 1;
      bit act = (c >= HB) && (l >= VB);
      bit vr = (idx == 0);
      bit e_vid, e_miss;
      logic [7:0] e_score;
      if (stop_at >= 0 && idx >= stop_at) break;
      hreset = (c == 0);
      vreset = vr;
      hblank = (c < HB);
      vblank = (l < VB);
      xdir   = (idx == hit_idx);
      if (do_miss && act && col == 2 && l < VB + 4) ball = 1'b1;
      else if (act && col < MC)                      ball = 1'b0;
      else                                           ball = ($urandom_range(3, 0) == 0);
      e_vid = act && exp_pix(col, row, m_score);
      e_miss = 0;
      if (vr) begin
        if (m_pm && !m_cool) begin
          m_score = 0; m_cool = 1; e_miss = 1;
        end else begin
          if (m_ph && m_score < 99) m_score++;
          if (m_cool && !m_pm) m_cool = 0;
        end
        m_ph = 0; m_pm = 0;
      end else begin
        if (xdir && !m_prev) m_ph = 1;
        if (ball && act && col < MC) m_pm = 1;
      end
      m_prev = xdir;
      e_score = bcd(m_score);
      @(posedge clk); #1;
      if (video !== e_vid) begin
        vid_err++;
        if (first_l < 0) begin first_l = l; first_c = c; end
      end
      if (miss) st_miss++;
      if (miss !== e_miss) miss_err++;
      if (video === 1'b1) begin
        if (!act) st_blank++;
        else if (row >= DY && row < DY + 20 && col >= DX && col < DX + 16) st_tens++;
        else if (row >= DY && row < DY + 20 && col >= DX + 16 && col < DX + 32) st_ones++;
      end
      if (vr) begin
        total++;
        if (score !== e_score) begin
          bad++;
          $display("FAIL score_commit: got %h expected %h", score, e_score);
        end
      end
    end
    total++;
    if (vid_err != 0) begin
      bad++;
      $display("FAIL video_frame: %0d mismatched pixels (first line %0d cycle %0d) expected 0",
               vid_err, first_l, first_c);
    end
    total++;
    if (miss_err != 0) begin
      bad++;
      $display("FAIL miss_pulse_frame: %0d mismatched cycles expected 0", miss_err);
    end
  endtask

  task automatic check_score(input string name, input logic [7:0] exp);
    total++;
    if (score !== exp) begin
      bad++;
      $display("FAIL %s: o_Score got %h expected %h", name, score, exp);
    end
  endtask

  task automatic test_reset();
    int lw = HB + R_HACT;
    #1;
    total++;
    if (score !== 8'h00 || video !== 1'b0 || miss !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial: score=%h video=%b miss=%b expected 00/0/0", score, video, miss);
    end
    release_reset();
    repeat (3) run_frame(F_HACT, F_VACT, 1, 0, -1);
    // Stop just after a lit pixel of the ones digit "3" (row 8, column 32).
    run_frame(R_HACT, R_VACT, 0, 0, (VB + 7) * lw + HB + 32 + 1);
    total++;
    if (video !== 1'b1 || score !== 8'h03) begin
      bad++;
      $display("FAIL pre_reset_state: video=%b score=%h expected 1/03", video, score);
    end
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (score !== 8'h00 || video !== 1'b0 || miss !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: score=%h video=%b miss=%b expected 00/0/0", score, video, miss);
    end
    release_reset();
    repeat (3) run_frame(R_HACT, R_VACT, 0, 0, -1);
    check_score("idle_frames", 8'h00);
  endtask

  task automatic test_count12();
    repeat (12) run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(R_HACT, R_VACT, 0, 0, -1);
    check_score("count_12", 8'h12);
  endtask

  task automatic test_bcd_edges();
    do_reset();
    repeat (9) run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(F_HACT, F_VACT, 0, 0, -1);
    check_score("score_09", 8'h09);
    run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(F_HACT, F_VACT, 0, 0, -1);
    check_score("carry_10", 8'h10);
    repeat (89) run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(F_HACT, F_VACT, 0, 0, -1);
    check_score("score_99", 8'h99);
    run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(R_HACT, R_VACT, 0, 0, -1);
    check_score("saturate_99", 8'h99);
  endtask

  task automatic test_miss_cooldown();
    int pulses = 0;
    for (int f = 0; f < 5; f++) begin
      run_frame(F_HACT, F_VACT, 0, 1, -1);
      pulses += st_miss;
    end
    run_frame(F_HACT, F_VACT, 1, 0, -1);
    pulses += st_miss;
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL miss_once: %0d pulses expected 1", pulses);
    end
    check_score("miss_clears", 8'h00);
    run_frame(F_HACT, F_VACT, 0, 1, -1);
    check_score("cooldown_hit", 8'h01);
    run_frame(F_HACT, F_VACT, 0, 0, -1);
    total++;
    if (st_miss != 1) begin
      bad++;
      $display("FAIL miss_after_idle: %0d pulses expected 1", st_miss);
    end
    check_score("second_miss", 8'h00);
  endtask

  task automatic test_hit_and_miss();
    run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(F_HACT, F_VACT, 1, 1, -1);
    check_score("before_both", 8'h02);
    run_frame(F_HACT, F_VACT, 0, 0, -1);
    total++;
    if (st_miss != 1 || score !== 8'h00) begin
      bad++;
      $display("FAIL miss_over_hit: pulses=%0d score=%h expected 1/00", st_miss, score);
    end
  endtask

  task automatic test_blank_tens();
    int exp_ones = 0;
    do_reset();
    repeat (7) run_frame(F_HACT, F_VACT, 1, 0, -1);
    run_frame(R_HACT, R_VACT, 0, 0, -1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 3; c++)
        exp_ones += ((font[7][r] >> (2 - c)) & 1) << (2 * SL);
    total++;
    if (st_tens != 0) begin
      bad++;
      $display("FAIL tens_blanked: %0d lit pixels expected 0", st_tens);
    end
    total++;
    if (st_ones != exp_ones) begin
      bad++;
      $display("FAIL ones_pixels: %0d lit pixels expected %0d", st_ones, exp_ones);
    end
    total++;
    if (st_blank != 0) begin
      bad++;
      $display("FAIL blank_video: %0d lit pixels expected 0", st_blank);
    end
    check_score("score_07", 8'h07);
  endtask

  initial begin
    set_idle();
    test_reset();
    test_count12();
    test_bcd_edges();
    test_miss_cooldown();
    test_hit_and_miss();
    test_blank_tens();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
